// File: rtl/data_bus_responder_if.sv
// Core data-bus signal bundle between the RISC-V core (master) and a memory responder (slave).
interface data_bus_responder_if;
  logic        rd_i;
  logic        wr_i;
  logic [2:0]  len_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        hlt_o;
  logic        berr_o;

  modport master (
    output rd_i, wr_i, len_i, addr_i, wdata_i,
    input  rdata_o, hlt_o, berr_o
  );

  modport slave (
    input  rd_i, wr_i, len_i, addr_i, wdata_i,
    output rdata_o, hlt_o, berr_o
  );
endinterface

// File: rtl/data_bus_responder.sv
// Data-bus responder: latches one core request, waits WAIT_STATES cycles, then serves it
// from a byte-enabled synchronous RAM, stalling the core via hlt_o and flagging bad accesses.
module data_bus_responder #(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1,
  parameter string       MEMORY_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  data_bus_responder_if.slave  bus
);

  localparam int          DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [32:0] SPAN  = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  WS4   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_rd, r_wr;
  logic [2:0]  r_len;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_berr;

  // NOTE: RAM array has no reset; contents survive reset and only the control path is cleared.
  logic [31:0] r_mem [DEPTH];

  logic                  w_req;
  logic                  w_hlt;
  logic [32:0]           w_offset;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [3:0]            w_be;
  logic                  w_len_ok;
  logic                  w_legal;

  assign w_req    = bus.rd_i | bus.wr_i;
  // 33-bit subtraction: an address below BASE_ADDR wraps to a huge offset and fails the range test.
  assign w_offset = {1'b0, r_addr} - {1'b0, BASE_ADDR};
  assign w_idx    = w_offset[ADDR_WIDTH+1:2];
  assign w_legal  = !(r_rd && r_wr) && w_len_ok && (w_offset < SPAN);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_be     = 4'b0000;
    w_len_ok = 1'b0;
    case (r_len)
      3'd1: begin
        w_be     = 4'b0001 << r_addr[1:0];
        w_len_ok = 1'b1;
      end
      3'd2: begin
        w_be     = 4'b0011 << r_addr[1:0];
        w_len_ok = !r_addr[0];
      end
      3'd4: begin
        w_be     = 4'b1111;
        w_len_ok = (r_addr[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_hlt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_hlt = w_req;
        if (w_req) w_next = (WS4 != 4'd0) ? S_WAIT : S_ACCESS;
      end
      S_WAIT: begin
        w_hlt = 1'b1;
        if (r_cnt == 4'd1) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_hlt  = 1'b1;
        w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_len   <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_berr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_berr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_rd    <= bus.rd_i;
            r_wr    <= bus.wr_i;
            r_len   <= bus.len_i;
            r_addr  <= bus.addr_i;
            r_wdata <= bus.wdata_i;
            r_cnt   <= WS4;
          end
        end
        S_WAIT: r_cnt <= r_cnt - 4'd1;
        S_ACCESS: begin
          r_berr <= !w_legal;
          if (!w_legal)  r_rdata <= 32'd0;
          else if (r_rd) r_rdata <= r_mem[w_idx];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && w_legal && r_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign bus.hlt_o   = w_hlt;
  assign bus.rdata_o = r_rdata;
  assign bus.berr_o  = r_berr;

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: two instances (1 and 3 wait states) checked
// against a byte-level memory model at every completed request.
module tb_data_bus_responder;

  localparam int          AW   = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          SPAN = 4 * (2 ** AW);

  typedef struct {
    string       tag;
    int          hlt_len;
    logic        berr;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_bus_responder_if bus0 ();
  data_bus_responder_if bus1 ();

  data_bus_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(1), .MEMORY_FILE(""))
    u_dut_ws1 (.clk(clk), .reset(reset), .bus(bus0));
  data_bus_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(3), .MEMORY_FILE(""))
    u_dut_ws3 (.clk(clk), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        q0 [$];
  exp_t        q1 [$];
  int          run [2];
  logic [31:0] rdm [2];
  logic [31:0] mm  [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_hlt(input int s);
    return (s == 0) ? bus0.hlt_o : bus1.hlt_o;
  endfunction

  task automatic drive(input int s, input logic rd, input logic wr, input logic [2:0] len,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (s == 0) begin
      bus0.rd_i = rd; bus0.wr_i = wr; bus0.len_i = len; bus0.addr_i = addr; bus0.wdata_i = wdata;
    end else begin
      bus1.rd_i = rd; bus1.wr_i = wr; bus1.len_i = len; bus1.addr_i = addr; bus1.wdata_i = wdata;
    end
  endtask

  // Reference model: legality, lane enables and memory update, then the expectation record.
  task automatic model(input int s, input string tag, input logic rd, input logic wr,
                       input logic [2:0] len, input logic [31:0] addr, input logic [31:0] wdata,
                       output exp_t e);
    bit          ok;
    logic [3:0]  be;
    logic [31:0] word;
    longint      off;
    int          key;
    off = longint'(addr) - longint'(BASE);
    ok  = !(rd && wr) && (off >= 0) && (off < SPAN);
    be  = 4'b0000;
    case (len)
      3'd1: case (addr[1:0])
              2'd0: be = 4'b0001;
              2'd1: be = 4'b0010;
              2'd2: be = 4'b0100;
              default: be = 4'b1000;
            endcase
      3'd2: begin
        if (addr[0]) ok = 1'b0;
        be = addr[1] ? 4'b1100 : 4'b0011;
      end
      3'd4: begin
        if (addr[1:0] != 2'b00) ok = 1'b0;
        be = 4'b1111;
      end
      default: ok = 1'b0;
    endcase
    key = s * 65536 + int'(off / 4);
    if (!ok) begin
      rdm[s] = 32'd0;
    end else if (wr) begin
      word = mm.exists(key) ? mm[key] : 32'd0;
      for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
      mm[key] = word;
    end else begin
      rdm[s] = mm.exists(key) ? mm[key] : 32'd0;
    end
    e.tag     = tag;
    e.hlt_len = (s == 0) ? 3 : 5;
    e.berr    = !ok;
    e.rdata   = rdm[s];
  endtask

  task automatic push(input int s, input exp_t e);
    if (s == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Bounded wait for the DONE cycle (hlt low again); caller is left in DONE at negedge+1.
  task automatic wait_done(input int s, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (!get_hlt(s)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic issue(input int s, input string tag, input logic rd, input logic wr,
                       input logic [2:0] len, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    @(posedge clk); #1;
    model(s, tag, rd, wr, len, addr, wdata, e);
    push(s, e);
    drive(s, rd, wr, len, addr, wdata);
    wait_done(s, tag);
    drive(s, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic mon_step(input int s, input logic hlt, input logic berr, input logic [31:0] rdata);
    exp_t e;
    if (!reset) begin
      run[s] = 0;
      return;
    end
    if (hlt) begin
      run[s]++;
      check($sformatf("berr_busy%0d", s), {31'd0, berr}, 32'd0);
    end else if (run[s] > 0) begin
      if (((s == 0) ? q0.size() : q1.size()) == 0) begin
        check($sformatf("sb_unexpected%0d", s), 32'd1, 32'd0);
      end else begin
        e = (s == 0) ? q0.pop_front() : q1.pop_front();
        check({e.tag, "_hlt_cycles"}, 32'(run[s]), 32'(e.hlt_len));
        check({e.tag, "_berr"}, {31'd0, berr}, {31'd0, e.berr});
        check({e.tag, "_rdata"}, rdata, e.rdata);
      end
      run[s] = 0;
    end else begin
      check($sformatf("berr_idle%0d", s), {31'd0, berr}, 32'd0);
    end
  endtask

  always @(negedge clk) mon_step(0, bus0.hlt_o, bus0.berr_o, bus0.rdata_o);
  always @(negedge clk) mon_step(1, bus1.hlt_o, bus1.berr_o, bus1.rdata_o);

  initial begin
    exp_t e;
    run[0] = 0; run[1] = 0;
    rdm[0] = 32'd0; rdm[1] = 32'd0;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hlt0", {31'd0, bus0.hlt_o}, 32'd0);
    check("rst_berr0", {31'd0, bus0.berr_o}, 32'd0);
    check("rst_rdata0", bus0.rdata_o, 32'd0);
    check("rst_rdata1", bus1.rdata_o, 32'd0);
    reset = 1'b1;

    // Word round trip
    issue(0, "t1_wr", 1'b0, 1'b1, 3'd4, BASE + 32'h8, 32'hDEAD_BEEF);
    issue(0, "t1_rd", 1'b1, 1'b0, 3'd4, BASE + 32'h8, 32'd0);

    // Byte lane write
    issue(0, "t2_pre", 1'b0, 1'b1, 3'd4, BASE + 32'h10, 32'h1122_3344);
    issue(0, "t2_wb",  1'b0, 1'b1, 3'd1, BASE + 32'h12, 32'hAAAA_AAAA);
    issue(0, "t2_rd",  1'b1, 1'b0, 3'd4, BASE + 32'h10, 32'd0);

    // Halfword writes
    issue(0, "t3_pre", 1'b0, 1'b1, 3'd4, BASE + 32'h20, 32'h0000_0000);
    issue(0, "t3_hhi", 1'b0, 1'b1, 3'd2, BASE + 32'h22, 32'h5566_5566);
    issue(0, "t3_hlo", 1'b0, 1'b1, 3'd2, BASE + 32'h20, 32'h7788_7788);
    issue(0, "t3_rd",  1'b1, 1'b0, 3'd4, BASE + 32'h20, 32'd0);

    // Misaligned and illegal accesses; target word must survive
    issue(0, "t4_pre",   1'b0, 1'b1, 3'd4, BASE + 32'h30, 32'hCAFE_F00D);
    issue(0, "t4_w4mis", 1'b0, 1'b1, 3'd4, BASE + 32'h32, 32'hFFFF_FFFF);
    issue(0, "t4_w2mis", 1'b0, 1'b1, 3'd2, BASE + 32'h31, 32'hFFFF_FFFF);
    issue(0, "t4_len3",  1'b0, 1'b1, 3'd3, BASE + 32'h30, 32'hFFFF_FFFF);
    issue(0, "t4_rdwr",  1'b1, 1'b1, 3'd4, BASE + 32'h30, 32'hFFFF_FFFF);
    issue(0, "t4_range", 1'b0, 1'b1, 3'd4, BASE + 32'(SPAN), 32'hFFFF_FFFF);
    issue(0, "t4_below", 1'b1, 1'b0, 3'd4, BASE - 32'd4, 32'd0);
    issue(0, "t4_rd",    1'b1, 1'b0, 3'd4, BASE + 32'h30, 32'd0);
    issue(0, "t4_rmis",  1'b1, 1'b0, 3'd4, BASE + 32'h31, 32'd0);

    // Last valid word is legal
    issue(0, "t4_lastw", 1'b0, 1'b1, 3'd4, BASE + 32'(SPAN) - 32'd4, 32'h0BAD_F00D);
    issue(0, "t4_lastr", 1'b1, 1'b0, 3'd4, BASE + 32'(SPAN) - 32'd4, 32'd0);

    // Wait-state timing and held strobe producing exactly one extra access
    issue(1, "t5_pre", 1'b0, 1'b1, 3'd4, BASE + 32'h60, 32'h1357_9BDF);
    @(posedge clk); #1;
    model(1, "t5_a", 1'b1, 1'b0, 3'd4, BASE + 32'h60, 32'd0, e);
    push(1, e);
    model(1, "t5_b", 1'b1, 1'b0, 3'd4, BASE + 32'h60, 32'd0, e);
    push(1, e);
    drive(1, 1'b1, 1'b0, 3'd4, BASE + 32'h60, 32'd0);
    wait_done(1, "t5_a");
    @(negedge clk); #1;
    check("t5_reissue_hlt", {31'd0, bus1.hlt_o}, 32'd1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    wait_done(1, "t5_b");

    // Reset asserted in the second WAIT cycle of a write
    issue(1, "t6_pre", 1'b0, 1'b1, 3'd4, BASE + 32'h50, 32'h0BAD_C0DE);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b1, 3'd4, BASE + 32'h50, 32'h1234_5678);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    check("t6_rst_hlt", {31'd0, bus1.hlt_o}, 32'd0);
    check("t6_rst_berr", {31'd0, bus1.berr_o}, 32'd0);
    check("t6_rst_rdata", bus1.rdata_o, 32'd0);
    rdm[0] = 32'd0;
    rdm[1] = 32'd0;
    @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    issue(1, "t6_rd", 1'b1, 1'b0, 3'd4, BASE + 32'h50, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty0", 32'(q0.size()), 32'd0);
    check("sb_empty1", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
